// File: rtl/filter_gin_receiver.sv
// Filter GIN receiver. Pops tagged filter words from the global-input NoC FIFOs,
// keeps only words addressed to this PE (exact ID or all-ones broadcast tag), and
// serializes each kept word lane by lane into the PE filter scratchpad.
module filter_gin_receiver #(
  parameter int unsigned FIFO_IN_WIDTH = 64,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ROW_TAG_WIDTH = 4,
  parameter int unsigned COL_TAG_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH   = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [ROW_TAG_WIDTH-1:0] row_id,
  input  logic [COL_TAG_WIDTH-1:0] col_id,
  input  logic [COUNT_WIDTH-1:0]   expected_count,
  input  logic                     gin_fifo_empty,
  output logic                     re_from_gin_fifo,
  input  logic [FIFO_IN_WIDTH-1:0] din,
  input  logic                     tags_fifo_empty,
  output logic                     re_from_tags_fifo,
  input  logic [ROW_TAG_WIDTH-1:0] row_tag,
  input  logic [COL_TAG_WIDTH-1:0] col_tag,
  input  logic                     spad_full,
  output logic                     we_to_spad,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [COUNT_WIDTH-1:0]   delivered
);

  localparam int unsigned Ratio = FIFO_IN_WIDTH / DATA_WIDTH;
  localparam int unsigned LaneW = (Ratio > 1) ? $clog2(Ratio) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e                   state_q, state_d;
  logic [FIFO_IN_WIDTH-1:0] shift_q, shift_d;
  logic [LaneW-1:0]         lane_q, lane_d;
  logic [COUNT_WIDTH-1:0]   delivered_q, delivered_d;
  logic [COUNT_WIDTH-1:0]   expected_q, expected_d;

  logic pop, match, write;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      lane_q      <= '0;
      delivered_q <= '0;
      expected_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      lane_q      <= lane_d;
      delivered_q <= delivered_d;
      expected_q  <= expected_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    lane_d      = lane_q;
    delivered_d = delivered_q;
    expected_d  = expected_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          expected_d  = expected_count;
          delivered_d = '0;
          state_d     = (expected_count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        // Non-matching pops simply drop the word and stay here
        if (pop && match) begin
          shift_d = din;
          lane_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (write) begin
          delivered_d = delivered_q + COUNT_WIDTH'(1);
          lane_d      = lane_q + LaneW'(1);
          // Job completion wins over word exhaustion; leftover lanes are dropped
          if (delivered_q + COUNT_WIDTH'(1) == expected_q) begin
            state_d = StDone;
          end else if (lane_q == LaneW'(Ratio - 1)) begin
            state_d = StLoad;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: handshakes are combinational so pops/writes happen in the same cycle
  always_comb begin
    match = ((row_tag == row_id) || (row_tag == '1)) &&
            ((col_tag == col_id) || (col_tag == '1));
    // Both FIFOs must be non-empty so data and tags never fall out of step
    pop   = (state_q == StLoad) && !gin_fifo_empty && !tags_fifo_empty;
    write = (state_q == StShift) && !spad_full;

    busy              = (state_q == StLoad) || (state_q == StShift);
    done              = (state_q == StDone);
    re_from_gin_fifo  = pop;
    re_from_tags_fifo = pop;
    we_to_spad        = write;
    dout              = shift_q[DATA_WIDTH*int'(lane_q) +: DATA_WIDTH];
    delivered         = delivered_q;
  end

endmodule

// File: tb/tb_filter_gin_receiver.sv
// Directed bench for filter_gin_receiver: show-ahead FIFO model on the input side,
// write logger on the scratchpad side, hand-computed expectations.
module tb_filter_gin_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done;
  logic [3:0]  row_id, col_id;
  logic [11:0] expected_count;
  logic        gin_fifo_empty, re_from_gin_fifo;
  logic [63:0] din;
  logic        tags_fifo_empty, re_from_tags_fifo;
  logic [3:0]  row_tag, col_tag;
  logic        spad_full, we_to_spad;
  logic [15:0] dout;
  logic [11:0] delivered;

  filter_gin_receiver dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .row_id           (row_id),
    .col_id           (col_id),
    .expected_count   (expected_count),
    .gin_fifo_empty   (gin_fifo_empty),
    .re_from_gin_fifo (re_from_gin_fifo),
    .din              (din),
    .tags_fifo_empty  (tags_fifo_empty),
    .re_from_tags_fifo(re_from_tags_fifo),
    .row_tag          (row_tag),
    .col_tag          (col_tag),
    .spad_full        (spad_full),
    .we_to_spad       (we_to_spad),
    .dout             (dout),
    .delivered        (delivered)
  );

  always #5 clk = ~clk;

  // Input FIFO model: the initial block appends at tail, the DUT pops at head
  logic [63:0] gmem [32];
  logic [7:0]  tmem [32];
  logic [4:0]  ghead = '0;
  logic [4:0]  gtail = '0;
  logic        tag_hide = 1'b0;
  int          pops = 0;

  assign gin_fifo_empty  = (ghead == gtail);
  assign tags_fifo_empty = (ghead == gtail) || tag_hide;
  assign din             = gmem[ghead];
  assign row_tag         = tmem[ghead][7:4];
  assign col_tag         = tmem[ghead][3:0];

  always @(posedge clk) begin
    if (re_from_gin_fifo) begin
      ghead <= ghead + 5'd1;
      pops  <= pops + 1;
    end
  end

  // Scratchpad logger
  logic [15:0] wlog [64];
  int          wcnt = 0;

  always @(posedge clk) begin
    if (we_to_spad) begin
      wlog[wcnt] <= dout;
      wcnt       <= wcnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w, input logic [7:0] t);
    gmem[gtail] = w;
    tmem[gtail] = t;
    gtail = gtail + 5'd1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic chk_writes(input string tag, input int base, input int n, input logic [15:0] v0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", tag, i), wlog[base+i], v0 + 16'(i));
    end
  endtask

  int wb, pb;

  initial begin
    for (int i = 0; i < 32; i++) begin
      gmem[i] = '0;
      tmem[i] = '0;
    end
    reset = 1'b0; start = 1'b0; spad_full = 1'b0;
    row_id = 4'd2; col_id = 4'd1; expected_count = '0;
    tick(); tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re_gin", re_from_gin_fifo, 0);
    chk("rst_re_tags", re_from_tags_fifo, 0);
    chk("rst_we", we_to_spad, 0);
    chk("rst_dout", dout, 0);
    chk("rst_delivered", delivered, 0);
    reset = 1'b1;
    tick();

    // Broadcast: two words, eight weights, cycle-exact timeline
    push(64'h0004_0003_0002_0001, 8'hFF);
    push(64'h0008_0007_0006_0005, 8'hFF);
    wb = wcnt; pb = pops;
    expected_count = 12'd8; start = 1'b1;
    tick(); start = 1'b0;                       // c1
    chk("bc_busy_c1", busy, 1);
    chk("bc_re_gin_c1", re_from_gin_fifo, 1);
    chk("bc_re_tags_c1", re_from_tags_fifo, 1);
    chk("bc_we_c1", we_to_spad, 0);
    tick();                                     // c2
    chk("bc_we_c2", we_to_spad, 1);
    chk("bc_dout_c2", dout, 16'h0001);
    chk("bc_re_c2", re_from_gin_fifo, 0);
    repeat (4) tick();                          // c6: gap cycle
    chk("bc_gap_we", we_to_spad, 0);
    chk("bc_gap_re", re_from_gin_fifo, 1);
    repeat (4) tick();                          // c10: last write
    chk("bc_we_c10", we_to_spad, 1);
    chk("bc_dout_c10", dout, 16'h0008);
    tick();                                     // c11
    chk("bc_done_c11", done, 1);
    chk("bc_busy_c11", busy, 0);
    chk("bc_delivered", delivered, 8);
    tick();                                     // c12
    chk("bc_done_c12", done, 0);
    chk("bc_delivered_hold", delivered, 8);
    chk("bc_nwrites", wcnt - wb, 8);
    chk("bc_npops", pops - pb, 2);
    chk_writes("bc", wb, 8, 16'h0001);

    // Tag filtering: (2,1) kept, (3,1) and (2,0) dropped, (2,1) kept
    push(64'h0014_0013_0012_0011, 8'h21);
    push(64'hDEAD_BEEF_DEAD_BEEF, 8'h31);
    push(64'hCAFE_CAFE_CAFE_CAFE, 8'h20);
    push(64'h0018_0017_0016_0015, 8'h21);
    wb = wcnt; pb = pops;
    expected_count = 12'd8; start = 1'b1;
    tick(); start = 1'b0;
    wait_done("tf_done");
    chk("tf_delivered", delivered, 8);
    chk("tf_nwrites", wcnt - wb, 8);
    chk("tf_npops", pops - pb, 4);
    chk_writes("tf", wb, 8, 16'h0011);
    tick();

    // Backpressure at lane 2 for three cycles
    push(64'h0024_0023_0022_0021, 8'hFF);
    wb = wcnt;
    expected_count = 12'd4; start = 1'b1;
    tick(); start = 1'b0;                       // c1 pop
    tick(); tick(); tick();                     // c4 at lane 2
    spad_full = 1'b1; #1;
    chk("bp_we_full0", we_to_spad, 0);
    chk("bp_dout_full0", dout, 16'h0023);
    for (int i = 1; i < 3; i++) begin
      tick();
      chk($sformatf("bp_we_full%0d", i), we_to_spad, 0);
      chk($sformatf("bp_dout_full%0d", i), dout, 16'h0023);
    end
    tick(); spad_full = 1'b0; #1;
    chk("bp_we_rel", we_to_spad, 1);
    chk("bp_dout_rel", dout, 16'h0023);
    tick();
    chk("bp_dout_l3", dout, 16'h0024);
    tick();
    chk("bp_done", done, 1);
    chk("bp_nwrites", wcnt - wb, 4);
    chk_writes("bp", wb, 4, 16'h0021);
    tick();

    // Partial word: six weights, third queued word must stay in the FIFO
    push(64'h0034_0033_0032_0031, 8'hFF);
    push(64'h0038_0037_0036_0035, 8'hFF);
    push(64'h0044_0043_0042_0041, 8'hFF);
    wb = wcnt; pb = pops;
    expected_count = 12'd6; start = 1'b1;
    tick(); start = 1'b0;
    wait_done("pw_done");
    chk("pw_delivered", delivered, 6);
    chk("pw_nwrites", wcnt - wb, 6);
    chk("pw_npops", pops - pb, 2);
    chk_writes("pw", wb, 6, 16'h0031);
    tick();
    chk("pw_no_third_pop", pops - pb, 2);

    // Misaligned FIFOs: data present, tags empty -> nothing popped
    tag_hide = 1'b1;
    wb = wcnt; pb = pops;
    expected_count = 12'd4; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mis_re_gin%0d", i), re_from_gin_fifo, 0);
      chk($sformatf("mis_re_tags%0d", i), re_from_tags_fifo, 0);
      tick();
    end
    chk("mis_npops", pops - pb, 0);
    tag_hide = 1'b0;
    wait_done("mis_done");
    chk("mis_nwrites", wcnt - wb, 4);
    chk_writes("mis", wb, 4, 16'h0041);
    tick();

    // Zero-length job
    wb = wcnt; pb = pops;
    push(64'h0074_0073_0072_0071, 8'hFF);
    expected_count = 12'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_re", re_from_gin_fifo, 0);
    chk("z_delivered", delivered, 0);
    tick();
    chk("z_done_low", done, 0);
    chk("z_npops", pops - pb, 0);
    chk("z_nwrites", wcnt - wb, 0);

    // Reset mid-SHIFT at lane 1 (FIFO head holds the 0x7x word from above)
    expected_count = 12'd4; start = 1'b1;
    tick(); start = 1'b0;                       // c1 pop
    tick(); tick();                             // c3 at lane 1
    chk("rs_dout_l1", dout, 16'h0072);
    chk("rs_delivered_pre", delivered, 1);
    reset = 1'b0; #1;
    chk("rs_busy", busy, 0);
    chk("rs_we", we_to_spad, 0);
    chk("rs_dout", dout, 0);
    chk("rs_delivered", delivered, 0);
    chk("rs_re", re_from_gin_fifo, 0);
    tick(); reset = 1'b1;
    tick();
    push(64'h0064_0063_0062_0061, 8'hFF);
    wb = wcnt;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("rs2_delivered_start", delivered, 0);
    wait_done("rs2_done");
    chk("rs2_delivered", delivered, 4);
    chk("rs2_nwrites", wcnt - wb, 4);
    chk_writes("rs2", wb, 4, 16'h0061);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
